// File: rtl/recip_diag_ctrl_if.sv
// Coefficient, reciprocal-unit and table-read channels of recip_diag_ctrl.
// Latency: n/a (wiring only). Backpressure: coefficient channel is valid/ready; others are fire-and-forget.
// Signal names are from the controller's point of view (i_ = into the controller).
interface recip_diag_ctrl_if #(
    parameter int IDX_W = 4
);
    logic             i_coef_valid;
    logic [7:0]       i_coef;
    logic             o_coef_ready;

    logic             o_recip_rst;
    logic             o_recip_valid;
    logic [7:0]       o_recip_divisor;
    logic             i_recip_valid;
    logic [31:0]      i_recip_quotient;

    logic             i_rd_en;
    logic [IDX_W-1:0] i_rd_idx;
    logic [31:0]      o_rd_data;
    logic             o_rd_valid;

    modport master (
        input  i_coef_valid, i_coef,
        output o_coef_ready,
        output o_recip_rst, o_recip_valid, o_recip_divisor,
        input  i_recip_valid, i_recip_quotient,
        input  i_rd_en, i_rd_idx,
        output o_rd_data, o_rd_valid
    );

    modport slave (
        output i_coef_valid, i_coef,
        input  o_coef_ready,
        input  o_recip_rst, o_recip_valid, o_recip_divisor,
        output i_recip_valid, i_recip_quotient,
        output i_rd_en, i_rd_idx,
        input  o_rd_data, o_rd_valid
    );
endinterface

// File: rtl/recip_diag_ctrl.sv
// Sequences diagonal coefficients through a one-shot reciprocal unit and tables the S1.30 results.
// Latency: reciprocal latency + 3 cycles per entry; table read 1 cycle. Backpressure: o_coef_ready only in LOAD.
// The reciprocal unit is held in reset in every state except REQ; zero divisors and hung responses are flagged.
module recip_diag_ctrl #(
    parameter int N_ROWS  = 16,
    parameter int IDX_W   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    recip_diag_ctrl_if.master       io_bus,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [31:0] SAT_RECIP = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_div;
    logic             r_err;
    logic [31:0]      r_table [N_ROWS];

    logic             r_coef_ready;
    logic             r_recip_rst;
    logic             r_recip_valid;
    logic             r_busy;
    logic             r_done;
    logic [31:0]      r_rd_data;
    logic             r_rd_valid;

    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       w_div_nxt;
    logic             w_err_nxt;
    logic             w_wr_en;
    logic [31:0]      w_wr_dat;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_err_nxt   = r_err;
        w_wr_en     = 1'b0;
        w_wr_dat    = '0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_err_nxt   = 1'b0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (io_bus.i_coef_valid) begin
                    w_div_nxt = io_bus.i_coef;
                    // A zero divisor never releases the unit; the entry saturates instead.
                    if (io_bus.i_coef == 8'd0) begin
                        w_wr_en     = 1'b1;
                        w_wr_dat    = SAT_RECIP;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_NEXT;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // Response is checked first so it wins over a coincident timeout.
                if (io_bus.i_recip_valid) begin
                    w_wr_en     = 1'b1;
                    w_wr_dat    = io_bus.i_recip_quotient;
                    w_state_nxt = S_NEXT;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_wr_en     = 1'b1;
                    w_wr_dat    = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_NEXT;
                end
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            S_NEXT: begin
                w_cnt_nxt = '0;
                if (r_idx == IDX_W'(N_ROWS - 1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_state_nxt = S_LOAD;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_div   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_div   <= w_div_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_coef_ready  <= 1'b0;
            r_recip_rst   <= 1'b1;
            r_recip_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_coef_ready  <= (w_state_nxt == S_LOAD);
            r_recip_rst   <= (w_state_nxt != S_REQ);
            r_recip_valid <= (w_state_nxt == S_REQ);
            r_busy        <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_REQ) ||
                             (w_state_nxt == S_NEXT);
            r_done        <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_ROWS; i++) begin
                r_table[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_table[r_idx] <= w_wr_dat;
        end
    end

    // Same-cycle read of an entry being written returns the pre-write contents.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= io_bus.i_rd_en;
            if (io_bus.i_rd_en) begin
                r_rd_data <= (int'(io_bus.i_rd_idx) < N_ROWS) ? r_table[io_bus.i_rd_idx] : '0;
            end
        end
    end

    assign io_bus.o_coef_ready    = r_coef_ready;
    assign io_bus.o_recip_rst     = r_recip_rst;
    assign io_bus.o_recip_valid   = r_recip_valid;
    assign io_bus.o_recip_divisor = r_div;
    assign io_bus.o_rd_data       = r_rd_data;
    assign io_bus.o_rd_valid      = r_rd_valid;
    assign o_busy                 = r_busy;
    assign o_done                 = r_done;
    assign o_err                  = r_err;

endmodule

// File: tb/tb_recip_diag_ctrl.sv
// Directed-random bench for recip_diag_ctrl with a one-shot reciprocal stub and a table reference model.
module tb_recip_diag_ctrl;

    localparam int N_ROWS  = 12;
    localparam int IDX_W   = 4;
    localparam int TIMEOUT = 63;
    localparam int BOUND   = 3000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    recip_diag_ctrl_if #(.IDX_W(IDX_W)) bus ();

    recip_diag_ctrl #(
        .N_ROWS (N_ROWS),
        .IDX_W  (IDX_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .io_bus (bus.master),
        .o_busy (busy),
        .o_done (done),
        .o_err  (err)
    );

    always #5 clk = ~clk;

    // Per-solve stimulus: coefficient per row and stub latency per row (-1 = never answers).
    logic [7:0] coefs [N_ROWS];
    int         lats  [N_ROWS];

    int         lat_q [$];
    logic [7:0] req_div [$];
    int         req_len [$];
    int         unstable, rst_viol, done_cnt;

    function automatic logic [31:0] recip_of(input logic [7:0] d);
        longint num, den;
        num = 64'sd1 <<< 30;
        den = longint'($signed(d));
        return 32'(num / den);
    endfunction

    function automatic logic [31:0] exp_entry(input logic [7:0] d, input int lat);
        if (d == 8'd0) return 32'h7FFF_FFFF;
        if (lat < 0)   return 32'h0;
        return recip_of(d);
    endfunction

    function automatic logic [7:0] rand_nz();
        logic [7:0] c;
        do c = 8'($urandom); while (c == 8'd0);
        return c;
    endfunction

    // One-shot reciprocal stub: answers once per release from reset, then sticks until reset.
    initial begin : stub
        bit s_active;
        int s_wait, s_lat;
        s_active = 0; s_wait = 0; s_lat = 0;
        bus.i_recip_valid    = 1'b0;
        bus.i_recip_quotient = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || bus.o_recip_rst) begin
                bus.i_recip_valid = 1'b0;
                s_active = 0;
            end else if (bus.o_recip_valid || s_active) begin
                if (!s_active) begin
                    s_active = 1;
                    s_wait   = 0;
                    s_lat    = 3;
                    if (lat_q.size() > 0) s_lat = lat_q.pop_front();
                end
                s_wait++;
                if (s_lat >= 0 && s_wait >= s_lat) begin
                    bus.i_recip_valid    = 1'b1;
                    bus.i_recip_quotient = recip_of(bus.o_recip_divisor);
                end
            end
        end
    end

    initial begin : monitor
        bit m_prev;
        m_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_prev = 0;
            end else begin
                if (bus.o_recip_valid) begin
                    if (bus.o_recip_rst) rst_viol++;
                    if (!m_prev) begin
                        req_div.push_back(bus.o_recip_divisor);
                        req_len.push_back(1);
                    end else begin
                        if (bus.o_recip_divisor !== req_div[req_div.size()-1]) unstable++;
                        req_len[req_len.size()-1]++;
                    end
                end
                if (done) done_cnt++;
                m_prev = bus.o_recip_valid;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rd(input logic [IDX_W-1:0] idx, output logic [31:0] data, output logic vld);
        bus.i_rd_en  = 1'b1;
        bus.i_rd_idx = idx;
        @(negedge clk);
        data = bus.o_rd_data;
        vld  = bus.o_rd_valid;
        bus.i_rd_en = 1'b0;
    endtask

    task automatic send_coef(input logic [7:0] c, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        bus.i_coef_valid = 1'b1;
        bus.i_coef       = c;
        while (!bus.o_coef_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("coef_handshake", 32'(n < BOUND), 32'(1));
        @(negedge clk);
        bus.i_coef_valid = 1'b0;
        bus.i_coef       = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_recip_rst"},   32'(bus.o_recip_rst),     32'(1));
        check({nm, "_recip_valid"}, 32'(bus.o_recip_valid),   32'(0));
        check({nm, "_divisor"},     32'(bus.o_recip_divisor), 32'(0));
        check({nm, "_coef_ready"},  32'(bus.o_coef_ready),    32'(0));
        check({nm, "_rd_data"},     bus.o_rd_data,            32'(0));
        check({nm, "_rd_valid"},    32'(bus.o_rd_valid),      32'(0));
        check({nm, "_busy"},        32'(busy),                32'(0));
        check({nm, "_done"},        32'(done),                32'(0));
        check({nm, "_err"},         32'(err),                 32'(0));
    endtask

    task automatic run_and_check(input string nm, input int gap_max, input int mid_start_row);
        int n, k, n_exp_req;
        logic [31:0] d;
        logic v;
        bit exp_err;
        lat_q = {}; req_div = {}; req_len = {};
        unstable = 0; rst_viol = 0; done_cnt = 0;
        n_exp_req = 0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (coefs[r] != 8'd0) begin
                lat_q.push_back(lats[r]);
                n_exp_req++;
            end
        end
        pulse_start();
        for (int r = 0; r < N_ROWS; r++) begin
            if (r == mid_start_row) pulse_start();
            send_coef(coefs[r], $urandom_range(0, gap_max));
        end
        n = 0;
        while (busy && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({nm, "_finish"},      32'(n < BOUND), 32'(1));
        check({nm, "_done_pulses"}, 32'(done_cnt),  32'(1));
        check({nm, "_busy_after"},  32'(busy),      32'(0));
        check({nm, "_n_requests"},  32'(req_div.size()), 32'(n_exp_req));
        exp_err = 0;
        k = 0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (coefs[r] == 8'd0) begin
                exp_err = 1;
            end else begin
                if (lats[r] < 0) exp_err = 1;
                if (k < req_div.size()) begin
                    check($sformatf("%s_req%0d_divisor", nm, r), 32'(req_div[k]), 32'(coefs[r]));
                    check($sformatf("%s_req%0d_cycles", nm, r), 32'(req_len[k]),
                          32'((lats[r] < 0) ? TIMEOUT : lats[r]));
                end
                k++;
            end
        end
        check({nm, "_err"},          32'(err),      32'(exp_err));
        check({nm, "_div_unstable"}, 32'(unstable), 32'(0));
        check({nm, "_rst_in_req"},   32'(rst_viol), 32'(0));
        for (int r = 0; r < N_ROWS; r++) begin
            rd(IDX_W'(r), d, v);
            check($sformatf("%s_table%0d", nm, r), d, exp_entry(coefs[r], lats[r]));
            check($sformatf("%s_rdvld%0d", nm, r), 32'(v), 32'(1));
        end
    endtask

    initial begin : main
        logic [31:0] d;
        logic v;
        int n;

        bus.i_coef_valid = 1'b0;
        bus.i_coef       = '0;
        bus.i_rd_en      = 1'b0;
        bus.i_rd_idx     = '0;
        unstable = 0; rst_viol = 0; done_cnt = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");
        rd(IDX_W'(0), d, v);
        check("post_rst_table0", d, 32'(0));

        // Solve A: powers of two, short latencies, response coinciding with timeout on row 5
        for (int r = 0; r < N_ROWS; r++) begin
            coefs[r] = rand_nz();
            lats[r]  = $urandom_range(1, 10);
        end
        coefs[0] = 8'd1; coefs[1] = 8'd2; coefs[2] = 8'd4;
        coefs[6] = 8'hFF;
        lats[5]  = TIMEOUT;
        run_and_check("A", 0, -1);
        check("A_pow2_row0", exp_entry(coefs[0], lats[0]), 32'h4000_0000);

        // Read port: latency, valid drop, out-of-range indices
        rd(IDX_W'(2), d, v);
        check("rd_idx2_data", d, 32'h1000_0000);
        check("rd_idx2_vld",  32'(v), 32'(1));
        @(negedge clk);
        check("rd_vld_drop",  32'(bus.o_rd_valid), 32'(0));
        rd(IDX_W'(N_ROWS), d, v);
        check("rd_oob_data",  d, 32'(0));
        check("rd_oob_vld",   32'(v), 32'(1));
        rd(IDX_W'(15), d, v);
        check("rd_max_idx",   d, 32'(0));

        // Solve B: timeout on row 0, zero divisor on row 3, stray start while busy, random gaps
        for (int r = 0; r < N_ROWS; r++) begin
            coefs[r] = rand_nz();
            lats[r]  = $urandom_range(5, 40);
        end
        lats[0]  = -1;
        coefs[3] = 8'd0;
        run_and_check("B", 6, 5);

        // Reset during REQ of row 5
        for (int r = 0; r < N_ROWS; r++) begin
            coefs[r] = rand_nz();
            lats[r]  = 30;
        end
        lat_q = {};
        for (int r = 0; r < N_ROWS; r++) lat_q.push_back(lats[r]);
        pulse_start();
        check("C_err_cleared", 32'(err),  32'(0));
        check("C_busy",        32'(busy), 32'(1));
        for (int r = 0; r < 6; r++) send_coef(coefs[r], 0);
        n = 0;
        while (!bus.o_recip_valid && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("C_in_req", 32'(bus.o_recip_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 6; r++) begin
            rd(IDX_W'(r), d, v);
            check($sformatf("midrst_table%0d", r), d, 32'(0));
        end
        check("midrst_idle", 32'(busy), 32'(0));

        // Solve D: full run after abort, zero divisor on the last row
        for (int r = 0; r < N_ROWS; r++) begin
            coefs[r] = rand_nz();
            lats[r]  = $urandom_range(5, 40);
        end
        coefs[N_ROWS-1] = 8'd0;
        run_and_check("D", 6, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/recip_diag_ctrl.md
Name: recip_diag_ctrl

Overview:
- Initiator for the 8-bit Newton-Raphson reciprocal unit in the Gauss-Seidel datapath.
- Accepts the N_ROWS diagonal coefficients a_ii and issues them one at a time to the reciprocal unit.
- Captures each S1.30 result into an internal N_ROWS x 32 table; the row-update engine reads 1/a_ii from that table.
- Handles the reciprocal unit's one-shot behaviour: the unit sticks in its output state, so it is held in reset between requests. Also handles zero divisors and hung responses.

Parameters:
- N_ROWS, 16, number of diagonal coefficients per solve (2..256).
- IDX_W, 4, width of the row index, equal to ceil(log2(N_ROWS)).
- TIMEOUT, 63, maximum cycles to wait for a reciprocal response before the entry is declared failed.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle pulse that begins a solve; ignored unless idle.
- i_coef_valid  in  1  coefficient offered.
- i_coef  in  8  signed diagonal coefficient a_ii.
- o_coef_ready  out  1  coefficient accepted when valid&&ready.
- o_recip_rst  out  1  active-high reset to the reciprocal unit.
- o_recip_valid  out  1  request valid to the reciprocal unit.
- o_recip_divisor  out  8  divisor to the reciprocal unit.
- i_recip_valid  in  1  reciprocal result valid.
- i_recip_quotient  in  32  reciprocal result, S1.30.
- i_rd_en  in  1  table read request.
- i_rd_idx  in  IDX_W  table read index.
- o_rd_data  out  32  table read data, S1.30.
- o_rd_valid  out  1  o_rd_data valid.
- o_busy  out  1  solve in progress.
- o_done  out  1  one-cycle pulse when all N_ROWS entries are written.
- o_err  out  1  sticky: a zero divisor or a timeout occurred in the current solve.

Behaviour:
- Reset values (async on i_rst_n=0):
  - o_recip_rst=1; o_recip_valid=0; o_recip_divisor=0; o_coef_ready=0.
  - o_rd_data=0; o_rd_valid=0; o_busy=0; o_done=0; o_err=0.
  - Table cleared to 0; row index=0; wait counter=0; FSM in IDLE.
- All outputs are registered.
- IDLE:
  - On i_start, clear o_err and the index, set o_busy=1, go to LOAD.
  - i_start in any other state is ignored.
- LOAD:
  - o_coef_ready=1 and o_recip_rst=1.
  - On i_coef_valid: latch i_coef into o_recip_divisor and drop o_coef_ready.
  - If i_coef==0: write 32'h7FFF_FFFF to table[idx], set o_err, go to NEXT. The reciprocal unit is never released.
  - Otherwise go to REQ.
- REQ:
  - o_recip_rst=0 and o_recip_valid=1.
  - o_recip_divisor is held stable for the whole state, because the reciprocal unit samples it continuously.
  - The wait counter increments every cycle.
  - On i_recip_valid: write i_recip_quotient to table[idx], go to NEXT.
  - If the counter reaches TIMEOUT with no response: write 0 to table[idx], set o_err, go to NEXT.
  - If response and timeout coincide, the response wins and o_err is not set.
- NEXT:
  - o_recip_valid=0, o_recip_rst=1, wait counter=0.
  - If idx==N_ROWS-1, go to DONE; otherwise idx++ and go to LOAD.
- DONE: o_done=1 for one cycle, o_busy=0, go to IDLE.
- o_recip_rst is 1 in every state except REQ. The reciprocal unit therefore always sees at least one reset edge before each request.
- i_recip_valid outside REQ is ignored.
- Negative divisors are forwarded unchanged; their accuracy is the reciprocal unit's responsibility.
- Read port:
  - Independent of the FSM; allowed in any state.
  - 1-cycle latency: o_rd_valid follows i_rd_en by one cycle.
  - If i_rd_idx>=N_ROWS, o_rd_data=0.
  - A read and a write to the same index in the same cycle returns the old value.
- Throughput: one coefficient per (reciprocal latency + 3) cycles. Typical is about 30 cycles per entry.
- Reset mid-solve aborts immediately. After release the block is IDLE, the table is zeroed, and i_start is required to begin again.

Test Plan:
- Power-of-two divisors with a real reciprocal instance: i_start, coefs 1,2,4 -> table[0]=32'h4000_0000, table[1]=32'h2000_0000, table[2]=32'h1000_0000; o_err=0; o_done pulses once after the last write.
- Zero divisor: coef 0 at row 3 -> table[3]=32'h7FFF_FFFF; o_err=1; o_recip_rst never deasserts for that row; rows 4.. still processed.
- Timeout: stub holds i_recip_valid=0 for row 0 -> exactly TIMEOUT cycles of o_recip_valid=1, then table[0]=0 and o_err=1; row 1 proceeds normally.
- Backpressure and stability: i_coef_valid with random gaps and a stub responding after 5..40 cycles -> o_recip_divisor constant throughout each REQ; one request per coefficient; N_ROWS entries written in order.
- Reset mid-solve: assert i_rst_n=0 during REQ of row 5 -> all outputs return to reset values asynchronously and table reads return 0; a new i_start then completes all N_ROWS entries.
- Read port: i_rd_en with idx 2 -> o_rd_data=table[2] one cycle later; idx N_ROWS -> 0; i_start pulsed while busy -> no effect.
